sumcheck_prover: RTL and testbench
==================================

Name: sumcheck_prover

Overview:
- Prover-side responder for the CMT sumcheck exchange of one circuit layer; the counterpart of the sumcheck verifier.
- Per round, sums f(z) = add(g,z)*(V(x)+V(y)) + mul(g,z)*V(x)*V(y) over the free label bits and emits the two sample points. It then accepts one random challenge bit and fixes that label bit.
- After the last round it presents the final wire values and gate-type flags, which the verifier uses for its closing check.

Parameters:
- UINT_WIDTH, 32, field/word width; all arithmetic is mod 2^UINT_WIDTH.
- NUM_LAYERS, 4, circuit depth.
- NUM_BITS, NUM_LAYERS-1, gate-label width; the concatenated label z is 2*NUM_BITS wide.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset: synchronous, active-low.
- start  in  1  one-cycle pulse; begins a layer run, sampled only in IDLE.
- curr_gate  in  NUM_BITS  output-gate label g; latched on start.
- claim_in  in  UINT_WIDTH  claimed layer value; latched on start (used only by the optional feature).
- val_addr_x, val_addr_y  out  NUM_BITS  wire-value read addresses.
- val_data_x, val_data_y  in  UINT_WIDTH  V(addr); fixed 1-cycle read latency.
- pred_add, pred_mul  in  1  wiring predicates for (curr_gate, val_addr_x, val_addr_y); combinational, valid in the same cycle as the address.
- sample_pts[2]  out  UINT_WIDTH each  round polynomial evaluated at bit 0 and bit 1.
- pts_valid  out  1  sample_pts valid; held until the challenge is taken.
- challenge, challenge_valid  in  1,1  verifier random bit and its strobe.
- rand_lbl  out  2*NUM_BITS  fixed label bits; bit r is fixed in round r.
- rand_vals[2]  out  UINT_WIDTH each  V(x), V(y) at the fully fixed label.
- is_add, is_valid  out  1,1  is_add = pred_add; is_valid = pred_add | pred_mul, at the fixed label.
- final_valid  out  1  final outputs valid.
- busy, done  out  1,1  busy asserted while not in IDLE/FINAL; done asserted in FINAL.

Behaviour:
- Label layout: z = {y, x}, with x = z[NUM_BITS-1:0] and y = z[2*NUM_BITS-1:NUM_BITS].
- Reset (nrst low at clk edge, from any state, including mid-round):
  - state IDLE; round = 0; rand_lbl = 0.
  - sample_pts = 0; rand_vals = 0.
  - all valid/flag outputs = 0; val_addr_* = 0; accumulators = 0.
- States:
  - IDLE: on start, latch g and claim, clear the accumulators, go to ACC.
  - ACC: counter c runs 0 .. 2^(2N-r)-1, one address per cycle. Issued z = {c, rand_lbl[r-1:0]} (N = NUM_BITS). Predicates are registered alongside the address. When the last address has been issued, go to DRAIN.
  - DRAIN: one cycle to absorb the final read; then load sample_pts, set pts_valid, go to OFFER.
  - OFFER: on challenge_valid, set rand_lbl[r] = challenge, clear pts_valid, clear the accumulators, r++. If r == 2N go to FINAL_RD, else go to ACC. The challenge is ignored in all other states.
  - FINAL_RD: issue z = rand_lbl for one cycle; next cycle load rand_vals, is_add and is_valid, set final_valid, go to FINAL.
  - FINAL: outputs held; done = 1. start returns to IDLE with rand_lbl cleared.
- Accumulation (one cycle after each address):
  - term = (add ? vx+vy : 0) + (mul ? vx*vy : 0); both predicates high means both terms are summed.
  - The term is added to acc[c_lsb], where c_lsb is bit r of the issued z.
  - Products and sums are truncated to UINT_WIDTH; wrap-around is legal.
- Round latency from entering ACC to pts_valid: 2^(2N-r)+1 cycles. Round 2N-1 sums exactly 2 points.
- start while busy: ignored.
- challenge_valid in the same cycle that pts_valid rises: not accepted. The challenge is taken from the following cycle onward.

Optional Feature:
- SUMCHECK_PROVER_SELFCHECK_EN: adds output consistency_err (1 bit, sticky until reset or start).
- Round 0 check: sample_pts[0]+sample_pts[1] must equal claim_in.
- Round r>0 check: the sum must equal the previous round's sample_pts[challenge].
- On mismatch, consistency_err is set in the cycle pts_valid rises.
- Without the macro the port is present and tied to 0.

Decomposition:
- Shared package cmt_pkg:
  - UINT_WIDTH default.
  - typedefs uint_t, gate_lbl_t, wire_lbl_t (2*NUM_BITS).
  - prover state enum.
  - helper function computing the term.
- One sub-module, sumcheck_accum: registered predicate/half-select stage plus the dual accumulator, with clear and load controls.

Test Plan:
- Single add gate, setup: N=2; V = [5,7,9,11]; gate 0 is an add gate with x=1, y=2, so the only nonzero z is 4'b1001.
  - Challenges 1,0,0,1 -> rounds give (0,16),(16,0),(16,0),(0,16).
  - Final: rand_vals = 7,9; is_add = 1; is_valid = 1.
- Same setup, challenge 0 in round 0 -> round 0 gives (0,16); rounds 1–3 give (0,0); final is_valid = 0, rand_lbl reflects the challenges.
- Mul gate with x=3, y=3 and V[3] = 0x10000 -> product wraps to 0 at 32 bits; sample_pts show 0.
- Reset asserted mid-ACC in round 2 -> next cycle state is IDLE, all outputs 0. A fresh start then reproduces the single-add-gate sequence.
- Challenge held off 5 cycles in OFFER -> sample_pts stable and pts_valid held throughout; round-0 ACC latency measured as 17 cycles (2^4 + 1).
- SELFCHECK_EN with claim_in = 15 against the single-add-gate setup (true sum 16) -> consistency_err = 1 in round 0 and stays set.

Source files
------------

// File: rtl/cmt_pkg.sv
// cmt_pkg: shared definitions for the CMT sumcheck prover.
//   CMT_UINT_WIDTH / CMT_NUM_LAYERS / CMT_NUM_BITS : default sizes
//   uint_t, gate_lbl_t, wire_lbl_t                 : word and label types
//   prover_state_t                                 : prover FSM state encoding
//   gate_term()                                    : per-label contribution
//                                                    add*(vx+vy) + mul*(vx*vy)
package cmt_pkg;

  localparam int CMT_UINT_WIDTH = 32;
  localparam int CMT_NUM_LAYERS = 4;
  localparam int CMT_NUM_BITS   = CMT_NUM_LAYERS - 1;

  typedef logic [CMT_UINT_WIDTH-1:0]   uint_t;
  typedef logic [CMT_NUM_BITS-1:0]     gate_lbl_t;
  typedef logic [2*CMT_NUM_BITS-1:0]   wire_lbl_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACC      = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_OFFER    = 3'd3,
    ST_FINAL_RD = 3'd4,
    ST_FINAL    = 3'd5
  } prover_state_t;

  // Both predicates high contributes both terms; everything wraps mod 2^W.
  function automatic uint_t gate_term(input logic add, input logic mul,
                                      input uint_t vx, input uint_t vy);
    uint_t s;
    uint_t p;
    uint_t t;
    s = vx + vy;
    p = vx * vy;
    t = '0;
    if (add) t = t + s;
    if (mul) t = t + p;
    return t;
  endfunction

endpackage

// File: rtl/sumcheck_accum.sv
// sumcheck_accum: one-stage predicate pipeline plus the two half-sum
// accumulators of a sumcheck round.
//   clk, nrst        : clock, synchronous active-low reset
//   issue            : an address is on the read port this cycle
//   pred_add/mul     : wiring predicates for that address
//   half             : label bit r of that address (selects acc[0]/acc[1])
//   clr              : zero both accumulators
//   val_data_x/y     : wire values, arriving one cycle after the address
//   acc_nxt          : accumulator contents including this cycle's term
module sumcheck_accum
  import cmt_pkg::*;
#(
  parameter int UINT_WIDTH = CMT_UINT_WIDTH
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       issue,
  input  logic                       pred_add,
  input  logic                       pred_mul,
  input  logic                       half,
  input  logic                       clr,
  input  logic [UINT_WIDTH-1:0]      val_data_x,
  input  logic [UINT_WIDTH-1:0]      val_data_y,
  output logic [1:0][UINT_WIDTH-1:0] acc_nxt
);

  logic                       v_q;
  logic                       add_q;
  logic                       mul_q;
  logic                       half_q;
  logic [1:0][UINT_WIDTH-1:0] acc_q;
  logic [UINT_WIDTH-1:0]      term;

  // Predicates are captured with the address so they line up with the
  // read data that returns one cycle later.
  always_comb begin
    term    = gate_term(add_q, mul_q, val_data_x, val_data_y);
    acc_nxt = acc_q;
    if (v_q) acc_nxt[half_q] = acc_q[half_q] + term;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      v_q    <= 1'b0;
      add_q  <= 1'b0;
      mul_q  <= 1'b0;
      half_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      v_q    <= issue;
      add_q  <= pred_add;
      mul_q  <= pred_mul;
      half_q <= half;
      acc_q  <= clr ? '0 : acc_nxt;
    end
  end

endmodule

// File: rtl/sumcheck_prover.sv
// sumcheck_prover: prover side of the CMT sumcheck for one circuit layer.
// Each round r sums f(z) over the free label bits (z = {y, x}), presents
// the two half sums on sample_pts, then fixes label bit r to the
// verifier's challenge. After 2*NUM_BITS rounds it reads V(x), V(y) and the
// gate type at the fixed label.
//
// Handshake: sample_pts is valid while pts_valid is high and stays stable
// until a challenge is taken. A challenge is taken on a clock edge where
// challenge_valid is high in OFFER, except in the first OFFER cycle (the
// cycle pts_valid rises), where it is ignored.
//
// Ports:
//   clk, nrst              clock, synchronous active-low reset
//   start                  begin a layer run (IDLE) / return to IDLE (FINAL)
//   curr_gate, claim_in    output-gate label and claimed value, latched on start
//   val_addr_x/y           wire-value read addresses (z[N-1:0], z[2N-1:N])
//   val_data_x/y           read data, one cycle after the address
//   pred_add/pred_mul      wiring predicates for the current address
//   sample_pts[1:0]        round polynomial at label bit r = 0 / 1
//   pts_valid              sample_pts valid
//   challenge(_valid)      verifier random bit and its strobe
//   rand_lbl               label bits fixed so far
//   rand_vals[1:0]         V(x), V(y) at the fixed label
//   is_add, is_valid       gate-type flags at the fixed label
//   final_valid, done      final outputs valid / in FINAL
//   busy                   not in IDLE or FINAL
//   consistency_err        sticky round-sum mismatch (0 unless
//                          SUMCHECK_PROVER_SELFCHECK_EN is defined)
//   dbg_state, dbg_round   FSM state and round counter
//   dbg_gate, dbg_claim    latched gate label and claim
//
// Optional build macro: SUMCHECK_PROVER_SELFCHECK_EN.
module sumcheck_prover
  import cmt_pkg::*;
#(
  parameter int UINT_WIDTH = CMT_UINT_WIDTH,
  parameter int NUM_LAYERS = CMT_NUM_LAYERS,
  parameter int NUM_BITS   = NUM_LAYERS - 1
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       start,
  input  logic [NUM_BITS-1:0]        curr_gate,
  input  logic [UINT_WIDTH-1:0]      claim_in,
  output logic [NUM_BITS-1:0]        val_addr_x,
  output logic [NUM_BITS-1:0]        val_addr_y,
  input  logic [UINT_WIDTH-1:0]      val_data_x,
  input  logic [UINT_WIDTH-1:0]      val_data_y,
  input  logic                       pred_add,
  input  logic                       pred_mul,
  output logic [1:0][UINT_WIDTH-1:0] sample_pts,
  output logic                       pts_valid,
  input  logic                       challenge,
  input  logic                       challenge_valid,
  output logic [2*NUM_BITS-1:0]      rand_lbl,
  output logic [1:0][UINT_WIDTH-1:0] rand_vals,
  output logic                       is_add,
  output logic                       is_valid,
  output logic                       final_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       consistency_err,
  output prover_state_t              dbg_state,
  output logic [7:0]                 dbg_round,
  output logic [NUM_BITS-1:0]        dbg_gate,
  output logic [UINT_WIDTH-1:0]      dbg_claim
);

  localparam int LW = 2 * NUM_BITS;
  localparam int RW = $clog2(LW + 1);

  prover_state_t              state;
  logic [RW-1:0]              rnd;
  logic [LW-1:0]              cnt;
  logic                       offer_arm;
  logic                       rd_phase;
  logic                       fin_add;
  logic                       fin_mul;
  logic [NUM_BITS-1:0]        gate_q;
  logic [UINT_WIDTH-1:0]      claim_q;

  logic [LW-1:0]              cnt_max;
  logic [LW-1:0]              issue_z;
  logic                       take;
  logic                       acc_clr;
  logic [1:0][UINT_WIDTH-1:0] acc_nxt;

  // Round r walks 2^(2N-r) free-label values; the low r bits come from the
  // challenges, so label bit r is always cnt[0].
  always_comb begin
    cnt_max = {LW{1'b1}} >> rnd;
    issue_z = '0;
    if (state == ST_ACC)
      issue_z = (cnt << rnd) | (rand_lbl & ~({LW{1'b1}} << rnd));
    else if (state == ST_FINAL_RD && !rd_phase)
      issue_z = rand_lbl;
  end

  assign val_addr_x = issue_z[NUM_BITS-1:0];
  assign val_addr_y = issue_z[LW-1:NUM_BITS];

  assign take    = (state == ST_OFFER) && offer_arm && challenge_valid;
  assign acc_clr = ((state == ST_IDLE) && start) || take;

  assign busy      = (state != ST_IDLE) && (state != ST_FINAL);
  assign done      = (state == ST_FINAL);
  assign dbg_state = state;
  assign dbg_round = 8'(rnd);
  assign dbg_gate  = gate_q;
  assign dbg_claim = claim_q;

  sumcheck_accum #(.UINT_WIDTH(UINT_WIDTH)) u_accum (
    .clk        (clk),
    .nrst       (nrst),
    .issue      (state == ST_ACC),
    .pred_add   (pred_add),
    .pred_mul   (pred_mul),
    .half       (cnt[0]),
    .clr        (acc_clr),
    .val_data_x (val_data_x),
    .val_data_y (val_data_y),
    .acc_nxt    (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= ST_IDLE;
      rnd         <= '0;
      cnt         <= '0;
      offer_arm   <= 1'b0;
      rd_phase    <= 1'b0;
      fin_add     <= 1'b0;
      fin_mul     <= 1'b0;
      gate_q      <= '0;
      claim_q     <= '0;
      rand_lbl    <= '0;
      sample_pts  <= '0;
      pts_valid   <= 1'b0;
      rand_vals   <= '0;
      is_add      <= 1'b0;
      is_valid    <= 1'b0;
      final_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            gate_q   <= curr_gate;
            claim_q  <= claim_in;
            rnd      <= '0;
            cnt      <= '0;
            rand_lbl <= '0;
            state    <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (cnt == cnt_max) begin
            cnt   <= '0;
            state <= ST_DRAIN;
          end else begin
            cnt <= cnt + LW'(1);
          end
        end
        ST_DRAIN: begin
          // acc_nxt already folds in the read of the last issued address.
          sample_pts <= acc_nxt;
          pts_valid  <= 1'b1;
          offer_arm  <= 1'b0;
          state      <= ST_OFFER;
        end
        ST_OFFER: begin
          offer_arm <= 1'b1;
          if (take) begin
            rand_lbl  <= rand_lbl | (LW'(challenge) << rnd);
            pts_valid <= 1'b0;
            rnd       <= rnd + RW'(1);
            if (rnd == RW'(LW - 1)) begin
              rd_phase <= 1'b0;
              state    <= ST_FINAL_RD;
            end else begin
              state <= ST_ACC;
            end
          end
        end
        ST_FINAL_RD: begin
          // Phase 0 issues the fixed label and captures its predicates;
          // phase 1 receives the read data.
          if (!rd_phase) begin
            fin_add  <= pred_add;
            fin_mul  <= pred_mul;
            rd_phase <= 1'b1;
          end else begin
            rand_vals   <= {val_data_y, val_data_x};
            is_add      <= fin_add;
            is_valid    <= fin_add | fin_mul;
            final_valid <= 1'b1;
            rd_phase    <= 1'b0;
            state       <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          if (start) begin
            rand_lbl    <= '0;
            final_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SUMCHECK_PROVER_SELFCHECK_EN
  logic                  err_q;
  logic [UINT_WIDTH-1:0] prev_pt;
  logic [UINT_WIDTH-1:0] pt_sum;
  logic [UINT_WIDTH-1:0] want_sum;

  // Round 0 must reproduce the claim; later rounds must reproduce the
  // previous round's polynomial at the chosen challenge.
  always_comb begin
    pt_sum   = acc_nxt[0] + acc_nxt[1];
    want_sum = (rnd == '0) ? claim_q : prev_pt;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      err_q   <= 1'b0;
      prev_pt <= '0;
    end else begin
      if ((state == ST_IDLE) && start)
        err_q <= 1'b0;
      else if ((state == ST_DRAIN) && (pt_sum != want_sum))
        err_q <= 1'b1;
      if (take) prev_pt <= sample_pts[challenge];
    end
  end

  assign consistency_err = err_q;
`else
  assign consistency_err = 1'b0;
`endif

endmodule

// File: tb/tb_sumcheck_prover.sv
// tb_sumcheck_prover: directed and randomized runs of sumcheck_prover with
// NUM_BITS = 2, checked against a label-space enumeration model.
module tb_sumcheck_prover;
  import cmt_pkg::*;

  localparam int W  = 32;
  localparam int N  = 2;
  localparam int LW = 2 * N;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT
  logic                start = 1'b0;
  logic [N-1:0]        curr_gate = '0;
  logic [W-1:0]        claim_in = '0;
  logic [N-1:0]        val_addr_x, val_addr_y;
  logic [W-1:0]        val_data_x = '0, val_data_y = '0;
  logic                pred_add, pred_mul;
  logic [1:0][W-1:0]   sample_pts, rand_vals;
  logic                pts_valid;
  logic                challenge = 1'b0, challenge_valid = 1'b0;
  logic [LW-1:0]       rand_lbl;
  logic                is_add, is_valid, final_valid, busy, done, consistency_err;
  prover_state_t       dbg_state;
  logic [7:0]          dbg_round;
  logic [N-1:0]        dbg_gate;
  logic [W-1:0]        dbg_claim;

  sumcheck_prover #(.UINT_WIDTH(W), .NUM_LAYERS(N + 1)) dut (
    .clk(clk), .nrst(nrst), .start(start), .curr_gate(curr_gate),
    .claim_in(claim_in), .val_addr_x(val_addr_x), .val_addr_y(val_addr_y),
    .val_data_x(val_data_x), .val_data_y(val_data_y),
    .pred_add(pred_add), .pred_mul(pred_mul), .sample_pts(sample_pts),
    .pts_valid(pts_valid), .challenge(challenge),
    .challenge_valid(challenge_valid), .rand_lbl(rand_lbl),
    .rand_vals(rand_vals), .is_add(is_add), .is_valid(is_valid),
    .final_valid(final_valid), .busy(busy), .done(done),
    .consistency_err(consistency_err), .dbg_state(dbg_state),
    .dbg_round(dbg_round), .dbg_gate(dbg_gate), .dbg_claim(dbg_claim)
  );

  // ---------------------------------------------------------------- environment
  logic [W-1:0] mem [4];
  bit           add_map [4][4][4];   // [gate][x][y]
  bit           mul_map [4][4][4];

  always @(posedge clk) begin
    val_data_x <= mem[val_addr_x];
    val_data_y <= mem[val_addr_y];
  end
  assign pred_add = add_map[curr_gate][val_addr_x][val_addr_y];
  assign pred_mul = mul_map[curr_gate][val_addr_x][val_addr_y];

  // ---------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  function automatic logic [W-1:0] f_at(input logic [3:0] z);
    logic [1:0]   x, y;
    logic [W-1:0] s, p, t;
    x = z[1:0];
    y = z[3:2];
    s = mem[x] + mem[y];
    p = mem[x] * mem[y];
    t = '0;
    if (add_map[curr_gate][x][y]) t = t + s;
    if (mul_map[curr_gate][x][y]) t = t + p;
    return t;
  endfunction

  // Sum of f over every label agreeing with lbl on bits below r and with b at bit r.
  function automatic logic [W-1:0] model_pt(input int r, input logic [3:0] lbl, input int b);
    logic [W-1:0] acc;
    logic [3:0]   zz;
    bit           ok;
    acc = '0;
    for (int z = 0; z < 16; z++) begin
      zz = 4'(z);
      ok = (int'(zz[r]) == b);
      for (int k = 0; k < r; k++) if (zz[k] != lbl[k]) ok = 0;
      if (ok) acc = acc + f_at(zz);
    end
    return acc;
  endfunction

  task automatic clear_env();
    for (int g = 0; g < 4; g++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 4; y++) begin
          add_map[g][x][y] = 0;
          mul_map[g][x][y] = 0;
        end
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    check({nm, "_pts0"},  sample_pts[0], 0);
    check({nm, "_pts1"},  sample_pts[1], 0);
    check({nm, "_pv"},    pts_valid, 0);
    check({nm, "_lbl"},   rand_lbl, 0);
    check({nm, "_rv"},    {rand_vals[1], rand_vals[0]}, 0);
    check({nm, "_flags"}, {is_add, is_valid, final_valid, busy, done, consistency_err}, 0);
    check({nm, "_addr"},  {val_addr_y, val_addr_x}, 0);
  endtask

  // ---------------------------------------------------------------- driver
  // One full layer run. All driving happens #1 after a rising edge.
  task automatic do_run(input string nm, input logic [3:0] chal, input int hold,
                        input bit poke, input int abort_round);
    logic [3:0]   lbl;
    logic [W-1:0] e0, e1, s, prev;
    bit           exp_err;
    int           cyc;
    lbl = '0;
    prev = '0;
    exp_err = 0;
    if (done) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("%s_back_idle", nm), {dbg_state == ST_IDLE, rand_lbl}, {1'b1, 4'h0});
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("%s_gate", nm), dbg_gate, curr_gate);
    for (int r = 0; r < LW; r++) begin
      e0 = model_pt(r, lbl, 0);
      e1 = model_pt(r, lbl, 1);
      if (r == abort_round) begin
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b0;
        @(posedge clk); #1;
        check_reset_state($sformatf("%s_abort", nm));
        nrst = 1'b1;
        return;
      end
      cyc = 0;
      while (!pts_valid && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      check($sformatf("%s_lat%0d", nm, r), cyc, (1 << (LW - r)) + 1);
      check($sformatf("%s_r%0d_p0", nm, r), sample_pts[0], e0);
      check($sformatf("%s_r%0d_p1", nm, r), sample_pts[1], e1);
      check($sformatf("%s_r%0d_busy", nm, r), {busy, done}, 2'b10);
      s = e0 + e1;
      if (r == 0 ? (s != claim_in) : (s != prev)) exp_err = 1;
`ifdef SUMCHECK_PROVER_SELFCHECK_EN
      check($sformatf("%s_r%0d_err", nm, r), consistency_err, exp_err);
`else
      check($sformatf("%s_r%0d_err", nm, r), consistency_err, 0);
`endif
      if (poke) begin
        // Challenge and start in the cycle pts_valid rises: both ignored.
        start = 1'b1;
        challenge = ~chal[r];
        challenge_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        challenge_valid = 1'b0;
        check($sformatf("%s_r%0d_early", nm, r), {pts_valid, rand_lbl}, {1'b1, lbl});
      end else begin
        @(posedge clk); #1;
      end
      for (int h = 0; h < hold; h++) begin
        check($sformatf("%s_r%0d_hold", nm, r), {pts_valid, sample_pts[1], sample_pts[0]}, {1'b1, e1, e0});
        @(posedge clk); #1;
      end
      challenge = chal[r];
      challenge_valid = 1'b1;
      @(posedge clk); #1;
      challenge_valid = 1'b0;
      lbl[r] = chal[r];
      prev = chal[r] ? e1 : e0;
      check($sformatf("%s_r%0d_taken", nm, r), {pts_valid, rand_lbl}, {1'b0, lbl});
    end
    cyc = 0;
    while (!final_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("%s_fin_lat", nm), cyc, 2);
    check($sformatf("%s_rv0", nm), rand_vals[0], mem[lbl[1:0]]);
    check($sformatf("%s_rv1", nm), rand_vals[1], mem[lbl[3:2]]);
    check($sformatf("%s_is_add", nm), is_add, add_map[curr_gate][lbl[1:0]][lbl[3:2]]);
    check($sformatf("%s_is_valid", nm), is_valid,
          add_map[curr_gate][lbl[1:0]][lbl[3:2]] | mul_map[curr_gate][lbl[1:0]][lbl[3:2]]);
    check($sformatf("%s_fin_lbl", nm), rand_lbl, lbl);
    check($sformatf("%s_fin_flags", nm), {busy, done}, 2'b01);
  endtask

  task automatic setup_single_add();
    clear_env();
    mem[0] = 5; mem[1] = 7; mem[2] = 9; mem[3] = 11;
    curr_gate = 2'd0;
    add_map[0][1][2] = 1;
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    logic [W-1:0] cl;
    clear_env();
    for (int i = 0; i < 4; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    nrst = 1'b1;
    @(posedge clk); #1;

    // Single add gate, challenges 1,0,0,1: (0,16),(16,0),(16,0),(0,16).
    setup_single_add();
    claim_in = 32'd16;
    do_run("add1001", 4'b1001, 0, 0, -1);
    check("add1001_r0_const", model_pt(0, 4'h0, 1), 16);
    check("add1001_rv_const", {rand_vals[1], rand_vals[0]}, {32'd9, 32'd7});
    check("add1001_flag_const", {is_add, is_valid}, 2'b11);

    // Challenge 0 in round 0 leaves the add gate behind.
    do_run("add_miss", 4'b0110, 1, 0, -1);
    check("add_miss_valid_const", is_valid, 0);

    // Multiply gate whose product wraps to zero.
    clear_env();
    mem[3] = 32'h0001_0000;
    mul_map[0][3][3] = 1;
    claim_in = 32'd0;
    do_run("mulwrap", 4'b1111, 0, 0, -1);
    check("mulwrap_p_const", {sample_pts[1], sample_pts[0]}, 64'd0);

    // Reset in the middle of round 2, then a fresh run.
    setup_single_add();
    claim_in = 32'd16;
    do_run("abort", 4'b1001, 0, 0, 2);
    do_run("after_abort", 4'b1001, 0, 0, -1);

    // Challenge held off five cycles, with early challenge/start pokes.
    do_run("hold5", 4'b1001, 5, 1, -1);

    // Wrong claim: self-check (when built in) flags round 0 and stays set.
    claim_in = 32'd15;
    do_run("badclaim", 4'b1001, 0, 0, -1);

    // Randomized layers.
    for (int t = 0; t < 10; t++) begin
      clear_env();
      for (int i = 0; i < 4; i++)
        mem[i] = ($urandom_range(0, 1) == 1) ? $urandom() : W'($urandom_range(0, 20));
      for (int g = 0; g < 4; g++)
        for (int x = 0; x < 4; x++)
          for (int y = 0; y < 4; y++) begin
            add_map[g][x][y] = ($urandom_range(0, 3) == 0);
            mul_map[g][x][y] = ($urandom_range(0, 3) == 0);
          end
      curr_gate = N'($urandom_range(0, 3));
      cl = model_pt(0, 4'h0, 0) + model_pt(0, 4'h0, 1);
      claim_in = ($urandom_range(0, 3) == 0) ? $urandom() : cl;
      do_run($sformatf("rnd%0d", t), 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), bit'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
